// File: rtl/mult_div_sequencer_pkg.sv
// Shared encodings for the multicycle MULT/DIV engine: opcode values,
// sequencer state codes and the default operand width.
package mult_div_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_LOAD = 3'd1,
    MD_RUN  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/mult_div_sequencer_step.sv
// One combinational iteration of the unsigned-magnitude engine:
// shift-add multiply step or restoring divide step on {acc, aux}.
module md_step
  import mult_div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] aux,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] aux_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (aux[0] ? {1'b0, operand} : '0);
    rem_sh   = {acc, aux[WIDTH-1]};
    // Only consumed when rem_sh >= operand, so the result always fits WIDTH bits.
    diff     = rem_sh[WIDTH-1:0] - operand;
    acc_next = sum[WIDTH:1];
    aux_next = {sum[0], aux[WIDTH-1:1]};
    if (op == OP_DIV) begin
      if (rem_sh >= {1'b0, operand}) begin
        acc_next = diff;
        aux_next = {aux[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_sh[WIDTH-1:0];
        aux_next = {aux[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multicycle signed MULT/DIV sequencer: latches operands, iterates md_step
// WIDTH times on magnitudes, applies signs and writes HI/LO.
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             DIV0,
  output logic             HiLoWrite,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  md_state_t        state;
  logic             op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] aux;
  logic [CNT_W-1:0] cnt;
  logic             div0;

  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   aux_next;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_r),
    .acc      (acc),
    .aux      (aux),
    .operand  (operand),
    .acc_next (acc_next),
    .aux_next (aux_next)
  );

  always_comb begin
    prod_s = {acc, aux};
    if (sign_a ^ sign_b)
      prod_s = '0 - {acc, aux};
    quot_s = (sign_a ^ sign_b) ? ('0 - aux) : aux;
    rem_s  = sign_a ? ('0 - acc) : acc;
    if (op_r == OP_DIV) begin
      res_hi = rem_s;
      res_lo = quot_s;
    end else begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state     <= MD_IDLE;
      op_r      <= OP_MULT;
      a_r       <= '0;
      b_r       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      aux       <= '0;
      cnt       <= '0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      DIV0      <= 1'b0;
      HiLoWrite <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            op_r  <= op;
            a_r   <= a_in;
            b_r   <= b_in;
            busy  <= 1'b1;
            state <= MD_LOAD;
          end
        end
        MD_LOAD: begin
          sign_a <= a_r[WIDTH-1];
          sign_b <= b_r[WIDTH-1];
          acc    <= '0;
          cnt    <= '0;
          div0   <= (op_r == OP_DIV) && (b_r == '0);
          if (op_r == OP_DIV) begin
            operand <= b_r[WIDTH-1] ? ('0 - b_r) : b_r;
            aux     <= a_r[WIDTH-1] ? ('0 - a_r) : a_r;
          end else begin
            operand <= a_r[WIDTH-1] ? ('0 - a_r) : a_r;
            aux     <= b_r[WIDTH-1] ? ('0 - b_r) : b_r;
          end
          // Divide-by-zero skips RUN but still retires through FIX, two edges after accept.
          state <= ((op_r == OP_DIV) && (b_r == '0)) ? MD_FIX : MD_RUN;
        end
        MD_RUN: begin
          acc <= acc_next;
          aux <= aux_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= MD_FIX;
        end
        MD_FIX: begin
          done <= 1'b1;
          if (div0) begin
            DIV0 <= 1'b1;
          end else begin
            HiLoWrite <= 1'b1;
            hi_out    <= res_hi;
            lo_out    <= res_lo;
          end
          state <= MD_DONE;
        end
        MD_DONE: begin
          done      <= 1'b0;
          DIV0      <= 1'b0;
          HiLoWrite <= 1'b0;
          busy      <= 1'b0;
          state     <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer against a plain signed-arithmetic
// reference model, with directed corner cases and randomized operations.
module tb_mult_div_sequencer;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;

  logic          clk;
  logic          reset_in;
  logic          start;
  logic          op;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic          DIV0;
  logic          HiLoWrite;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;

  int vectors;
  int miscompares;
  logic [W-1:0] hold_hi;
  logic [W-1:0] hold_lo;

  mult_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .DIV0      (DIV0),
    .HiLoWrite (HiLoWrite),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic op_m, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op_m == 1'b0) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Drives one operation and reports what was seen at the done pulse and one cycle later.
  task automatic run_op(input logic op_i, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] g_hi, output logic [W-1:0] g_lo,
                        output logic g_dz, output logic g_hlw, output logic g_busy,
                        output logic g_next_busy, output logic g_next_done);
    @(negedge clk);
    start = 1'b1; op = op_i; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    g_hi = hi_out; g_lo = lo_out; g_dz = DIV0; g_hlw = HiLoWrite; g_busy = busy;
    @(posedge clk); #1;
    g_next_busy = busy; g_next_done = done;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, DIV0, HiLoWrite, hi_out, lo_out} !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b DIV0=%b hlw=%b hi=%h lo=%h, required all 0",
               busy, done, DIV0, HiLoWrite, hi_out, lo_out);
    end
    reset_in = 1'b0;
    hold_hi = '0; hold_lo = '0;
  endtask

  task automatic test_directed(input string name, input logic op_i, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] req_hi,
                               input logic [W-1:0] req_lo);
    int lat;
    logic [W-1:0] g_hi, g_lo;
    logic g_dz, g_hlw, g_busy, n_busy, n_done;
    run_op(op_i, a, b, lat, g_hi, g_lo, g_dz, g_hlw, g_busy, n_busy, n_done);
    vectors++;
    if (g_hi !== req_hi || g_lo !== req_lo) begin
      miscompares++;
      $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", name, g_hi, g_lo, req_hi, req_lo);
    end
    vectors++;
    if (lat != LAT || g_hlw !== 1'b1 || g_dz !== 1'b0 || g_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timing: lat=%0d hlw=%b DIV0=%b busy=%b, required lat=%0d hlw=1 DIV0=0 busy=1",
               name, lat, g_hlw, g_dz, g_busy, LAT);
    end
    vectors++;
    if (n_busy !== 1'b0 || n_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: busy=%b done=%b after done, required 0 0", name, n_busy, n_done);
    end
    hold_hi = req_hi; hold_lo = req_lo;
  endtask

  task automatic test_div0();
    int lat;
    logic [W-1:0] g_hi, g_lo;
    logic g_dz, g_hlw, g_busy, n_busy, n_done;
    run_op(1'b1, 32'd5, 32'd0, lat, g_hi, g_lo, g_dz, g_hlw, g_busy, n_busy, n_done);
    vectors++;
    if (lat != 2 || g_dz !== 1'b1 || g_hlw !== 1'b0) begin
      miscompares++;
      $display("FAIL div0 flags: lat=%0d DIV0=%b hlw=%b, required lat=2 DIV0=1 hlw=0", lat, g_dz, g_hlw);
    end
    vectors++;
    if (g_hi !== hold_hi || g_lo !== hold_lo) begin
      miscompares++;
      $display("FAIL div0 hold: hi=%h lo=%h, required hi=%h lo=%h", g_hi, g_lo, hold_hi, hold_lo);
    end
    vectors++;
    if (n_busy !== 1'b0 || n_done !== 1'b0) begin
      miscompares++;
      $display("FAIL div0 release: busy=%b done=%b, required 0 0", n_busy, n_done);
    end
  endtask

  task automatic test_random(input int count);
    int lat;
    logic [W-1:0] a, b, g_hi, g_lo, e_hi, e_lo;
    logic op_i, e_dz, g_dz, g_hlw, g_busy, n_busy, n_done;
    int exp_lat;
    for (int i = 0; i < count; i++) begin
      op_i = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 9));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(op_i, a, b, e_hi, e_lo, e_dz);
      if (e_dz) begin
        e_hi = hold_hi; e_lo = hold_lo;
      end
      exp_lat = e_dz ? 2 : LAT;
      run_op(op_i, a, b, lat, g_hi, g_lo, g_dz, g_hlw, g_busy, n_busy, n_done);
      vectors++;
      if (g_hi !== e_hi || g_lo !== e_lo || g_dz !== e_dz || g_hlw !== !e_dz || lat != exp_lat) begin
        miscompares++;
        $display("FAIL random op=%b a=%h b=%h: hi=%h lo=%h DIV0=%b hlw=%b lat=%0d, required hi=%h lo=%h DIV0=%b hlw=%b lat=%0d",
                 op_i, a, b, g_hi, g_lo, g_dz, g_hlw, lat, e_hi, e_lo, e_dz, !e_dz, exp_lat);
      end
      hold_hi = e_hi; hold_lo = e_lo;
    end
  endtask

  task automatic test_back_to_back();
    int dones, first_done;
    logic [W-1:0] g_hi, g_lo, e_hi, e_lo;
    logic e_dz;
    model(1'b0, 32'h0001_2345, 32'hFFFF_6789, e_hi, e_lo, e_dz);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 32'h0001_2345; b_in = 32'hFFFF_6789;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first_done = -1; g_hi = '0; g_lo = '0;
    for (int n = 1; n <= LAT + 10; n++) begin
      if (n == 5) begin
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done < 0) begin
          first_done = n; g_hi = hi_out; g_lo = lo_out;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (dones != 1 || first_done != LAT) begin
      miscompares++;
      $display("FAIL busy_start done count: dones=%0d at %0d, required 1 at %0d", dones, first_done, LAT);
    end
    vectors++;
    if (g_hi !== e_hi || g_lo !== e_lo) begin
      miscompares++;
      $display("FAIL busy_start result: hi=%h lo=%h, required hi=%h lo=%h", g_hi, g_lo, e_hi, e_lo);
    end
    hold_hi = e_hi; hold_lo = e_lo;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 32'h0000_7777; b_in = 32'h0000_0123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi_out, lo_out);
    end
    hold_hi = '0; hold_lo = '0;
    test_directed("after_abort_3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed("mult_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    test_directed("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_div0();
    test_directed("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    test_directed("mult_minxmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    test_random(24);
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
